range_ctrl: RTL

RANGE_CTRL -- requirements
Module: range_ctrl

---
 rtl/range_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/range_ctrl.sv
// Bounded up/down/bounce/one-shot counter with a valid/ready configuration port.
// The configuration is accepted only in IDLE or ARMED. A run starts from ARMED and
// ends on stop, on reaching the pass limit, or at the top of a one-shot sweep.
module range_ctrl #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned LOOPW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] cfg_hi,
  input  logic [1:0]       cfg_mode,
  input  logic [LOOPW-1:0] cfg_loops,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             dir,
  output logic             wrap,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {StIdle, StArmed, StRun, StDone} state_e;

  localparam logic [1:0] ModeUp     = 2'b00;
  localparam logic [1:0] ModeDown   = 2'b01;
  localparam logic [1:0] ModeBounce = 2'b10;
  localparam logic [1:0] ModeOnce   = 2'b11;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [1:0]       mode_q, mode_d;
  logic [LOOPW-1:0] loops_q, loops_d;
  logic [LOOPW-1:0] pass_q, pass_d;
  logic             dir_q, dir_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             xfer;
  logic             hit;

  // Next-state, configuration latching, count stepping and registered-output values
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    mode_d  = mode_q;
    loops_d = loops_q;
    pass_d  = pass_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    hit     = 1'b0;
    xfer    = cfg_valid && ready_q;

    unique case (state_q)
      StIdle, StArmed: begin
        if (xfer) begin
          // A transfer always beats start in the same cycle
          if (cfg_lo <= cfg_hi) begin
            lo_d    = cfg_lo;
            hi_d    = cfg_hi;
            mode_d  = cfg_mode;
            loops_d = cfg_loops;
            pass_d  = '0;
            state_d = StArmed;
            if (cfg_mode == ModeDown) begin
              count_d = cfg_hi;
              dir_d   = 1'b0;
            end else begin
              count_d = cfg_lo;
              dir_d   = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (state_q == StArmed && start && !stop) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StArmed;
        end else begin
          unique case (mode_q)
            ModeUp: begin
              if (count_q == hi_q) begin
                count_d = lo_q;
                hit     = 1'b1;
              end else begin
                count_d = count_q + WIDTH'(1);
              end
            end
            ModeDown: begin
              if (count_q == lo_q) begin
                count_d = hi_q;
                hit     = 1'b1;
              end else begin
                count_d = count_q - WIDTH'(1);
              end
            end
            ModeBounce: begin
              if (lo_q == hi_q) begin
                // Degenerate range: hold and just flip direction
                dir_d = ~dir_q;
                hit   = 1'b1;
              end else if (dir_q && count_q == hi_q) begin
                dir_d   = 1'b0;
                count_d = hi_q - WIDTH'(1);
                hit     = 1'b1;
              end else if (!dir_q && count_q == lo_q) begin
                dir_d   = 1'b1;
                count_d = lo_q + WIDTH'(1);
                hit     = 1'b1;
              end else if (dir_q) begin
                count_d = count_q + WIDTH'(1);
              end else begin
                count_d = count_q - WIDTH'(1);
              end
            end
            ModeOnce: begin
              if (count_q == hi_q) begin
                hit = 1'b1;
              end else begin
                count_d = count_q + WIDTH'(1);
              end
            end
          endcase
          if (hit) begin
            wrap_d = 1'b1;
            pass_d = pass_q + LOOPW'(1);
            if (mode_q == ModeOnce || (loops_q != '0 && pass_d == loops_q)) begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle) || (state_d == StArmed);
    busy_d  = (state_d == StRun);
    done_d  = (state_d == StDone);
  end

  // State and output registers; reset is asynchronous
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= '0;
      lo_q    <= '0;
      hi_q    <= '1;
      mode_q  <= ModeUp;
      loops_q <= '0;
      pass_q  <= '0;
      dir_q   <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      mode_q  <= mode_d;
      loops_q <= loops_d;
      pass_q  <= pass_d;
      dir_q   <= dir_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cfg_ready = ready_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign dir       = dir_q;
  assign wrap      = wrap_q;
  assign done      = done_q;
  assign cfg_err   = err_q;

endmodule
